// File: rtl/wb_serial_master.sv
// wb_serial_master: UART byte stream to Wishbone bridge for host peek/poke.
// Commands: 'W' + 4 address + 4 data bytes (write), 'R' + 4 address bytes
// (read), both fields MSB first. Responses: 'K' (+4 read bytes) on ack,
// 'E' on timeout, '?' for an unknown command byte.
// Ports:
//   clk, reset_n                 clock, synchronous active-low reset
//   rx_data/rx_avail/rx_ack      UART receive byte interface
//   tx_data/tx_wr/tx_busy        UART transmit byte interface
//   wb_*                         Wishbone master (single classic cycles)
//   busy                         high while a command is in progress
module wb_serial_master #(
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [7:0]  rx_data,
  input  logic        rx_avail,
  output logic        rx_ack,
  output logic [7:0]  tx_data,
  output logic        tx_wr,
  input  logic        tx_busy,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  output logic        wb_we_o,
  output logic [31:0] wb_adr_o,
  output logic [3:0]  wb_sel_o,
  output logic [31:0] wb_dat_o,
  input  logic [31:0] wb_dat_i,
  input  logic        wb_ack_i,
  output logic        busy
);

  localparam int unsigned CNT_W = 16;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TIMEOUT - 1);
  localparam logic [7:0] CMD_WR  = 8'h57;
  localparam logic [7:0] CMD_RD  = 8'h52;
  localparam logic [7:0] RSP_OK  = 8'h4B;
  localparam logic [7:0] RSP_ERR = 8'h45;
  localparam logic [7:0] RSP_BAD = 8'h3F;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_DATA,
    S_BUS,
    S_RESP
  } state_t;

  state_t           state;
  logic [1:0]       byte_cnt;
  logic [2:0]       resp_cnt;
  logic [2:0]       resp_last;
  logic [CNT_W-1:0] timer;
  logic             is_write;
  logic [7:0]       status;
  logic [31:0]      rd_data;

  // A set rx_ack / tx_wr marks the cycle right after a handshake, in which
  // the UART flags may still be stale and must not be trusted.
  logic       take_c;
  logic       send_c;
  logic [7:0] resp_byte_c;

  assign take_c = rx_avail && !rx_ack;
  assign send_c = !tx_busy && !tx_wr;

  // Response byte 0 is the status, bytes 1..4 the read data MSB first.
  always_comb begin
    resp_byte_c = status;
    case (resp_cnt)
      3'd1:    resp_byte_c = rd_data[31:24];
      3'd2:    resp_byte_c = rd_data[23:16];
      3'd3:    resp_byte_c = rd_data[15:8];
      3'd4:    resp_byte_c = rd_data[7:0];
      default: resp_byte_c = status;
    endcase
  end

  // Command FSM with all outputs registered.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      byte_cnt  <= 2'd0;
      resp_cnt  <= 3'd0;
      resp_last <= 3'd0;
      timer     <= '0;
      is_write  <= 1'b0;
      status    <= 8'd0;
      rd_data   <= 32'd0;
      rx_ack    <= 1'b0;
      tx_wr     <= 1'b0;
      tx_data   <= 8'd0;
      wb_cyc_o  <= 1'b0;
      wb_stb_o  <= 1'b0;
      wb_we_o   <= 1'b0;
      wb_adr_o  <= 32'd0;
      wb_sel_o  <= 4'd0;
      wb_dat_o  <= 32'd0;
      busy      <= 1'b0;
    end else begin
      rx_ack <= 1'b0;
      tx_wr  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (take_c) begin
            rx_ack   <= 1'b1;
            busy     <= 1'b1;
            byte_cnt <= 2'd0;
            resp_cnt <= 3'd0;
            if (rx_data == CMD_WR || rx_data == CMD_RD) begin
              is_write <= (rx_data == CMD_WR);
              state    <= S_ADDR;
            end else begin
              status    <= RSP_BAD;
              resp_last <= 3'd0;
              state     <= S_RESP;
            end
          end
        end

        S_ADDR: begin
          if (take_c) begin
            rx_ack   <= 1'b1;
            wb_adr_o <= {wb_adr_o[23:0], rx_data};
            byte_cnt <= byte_cnt + 2'd1;
            if (byte_cnt == 2'd3) begin
              if (is_write) begin
                state <= S_DATA;
              end else begin
                wb_cyc_o <= 1'b1;
                wb_stb_o <= 1'b1;
                wb_we_o  <= 1'b0;
                wb_sel_o <= 4'hF;
                timer    <= '0;
                state    <= S_BUS;
              end
            end
          end
        end

        S_DATA: begin
          if (take_c) begin
            rx_ack   <= 1'b1;
            wb_dat_o <= {wb_dat_o[23:0], rx_data};
            byte_cnt <= byte_cnt + 2'd1;
            if (byte_cnt == 2'd3) begin
              wb_cyc_o <= 1'b1;
              wb_stb_o <= 1'b1;
              wb_we_o  <= 1'b1;
              wb_sel_o <= 4'hF;
              timer    <= '0;
              state    <= S_BUS;
            end
          end
        end

        S_BUS: begin
          // Ack is tested first so it wins over a coinciding timeout.
          if (wb_ack_i || timer == LAST_CNT) begin
            wb_cyc_o <= 1'b0;
            wb_stb_o <= 1'b0;
            wb_we_o  <= 1'b0;
            wb_sel_o <= 4'd0;
            resp_cnt <= 3'd0;
            state    <= S_RESP;
            if (wb_ack_i) begin
              status    <= RSP_OK;
              resp_last <= is_write ? 3'd0 : 3'd4;
              if (!is_write) begin
                rd_data <= wb_dat_i;
              end
            end else begin
              status    <= RSP_ERR;
              resp_last <= 3'd0;
            end
          end else begin
            timer <= timer + CNT_W'(1);
          end
        end

        S_RESP: begin
          if (send_c) begin
            tx_wr    <= 1'b1;
            tx_data  <= resp_byte_c;
            resp_cnt <= resp_cnt + 3'd1;
            if (resp_cnt == resp_last) begin
              busy  <= 1'b0;
              state <= S_IDLE;
            end
          end
        end

        default: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wb_serial_master.sv
// Testbench for wb_serial_master: table of command vectors with hand-computed
// responses, plus reset-during-bus and back-to-back streaming sequences.
// Models a UART receive FIFO, a UART transmitter with a busy window and a
// Wishbone slave with programmable ack latency.
module tb_wb_serial_master;

  localparam int unsigned TO = 8;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [7:0]  rx_data;
  logic        rx_avail;
  logic        rx_ack;
  logic [7:0]  tx_data;
  logic        tx_wr;
  logic        tx_busy;
  logic        wb_cyc_o;
  logic        wb_stb_o;
  logic        wb_we_o;
  logic [31:0] wb_adr_o;
  logic [3:0]  wb_sel_o;
  logic [31:0] wb_dat_o;
  logic [31:0] wb_dat_i;
  logic        wb_ack_i;
  logic        busy;

  always #5 clk = ~clk;

  wb_serial_master #(.TIMEOUT(TO)) dut (
    .clk(clk), .reset_n(reset_n),
    .rx_data(rx_data), .rx_avail(rx_avail), .rx_ack(rx_ack),
    .tx_data(tx_data), .tx_wr(tx_wr), .tx_busy(tx_busy),
    .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o),
    .wb_adr_o(wb_adr_o), .wb_sel_o(wb_sel_o), .wb_dat_o(wb_dat_o),
    .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i), .busy(busy)
  );

  int checks = 0;
  int fails  = 0;
  int cyc_n  = 0;

  always @(posedge clk) cyc_n <= cyc_n + 1;

  // Wishbone slave: ack on the cycle where stb has been high for ack_lat cycles.
  logic        ack_en  = 1'b0;
  int          ack_lat = 0;
  logic [31:0] rd_val  = 32'd0;
  int          stb_cnt = 0;
  always @(posedge clk) stb_cnt <= (wb_cyc_o && wb_stb_o) ? stb_cnt + 1 : 0;
  assign wb_ack_i = wb_cyc_o && wb_stb_o && ack_en && (stb_cnt == ack_lat);
  assign wb_dat_i = rd_val;

  // UART transmitter: busy for busy_len cycles, starting the cycle after tx_wr.
  int busy_len = 0;
  int busy_cnt = 0;
  always @(posedge clk) begin
    if (tx_wr) busy_cnt <= busy_len;
    else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
  end
  assign tx_busy = (busy_cnt != 0);

  // UART receiver FIFO, popped on each rx_ack.
  logic [7:0] rx_buf [256];
  logic [7:0] rd_ptr = 8'd0;
  logic [7:0] wr_ptr = 8'd0;
  always @(posedge clk) if (rx_ack && rd_ptr != wr_ptr) rd_ptr <= rd_ptr + 8'd1;
  assign rx_avail = (rd_ptr != wr_ptr);
  assign rx_data  = rx_buf[rd_ptr];

  // Monitor: transmit log, handshake spacing and bus-cycle shape.
  logic [7:0]  tx_log [256];
  int          tx_cyc [256];
  int          tx_n = 0, rxack_n = 0, last_rxack_cyc = 0;
  int          bus_n = 0, cur_run = 0, last_run = 0;
  logic [31:0] last_adr = 32'd0, last_dat = 32'd0;
  logic        last_we = 1'b0;
  int          viol_tx = 0, viol_tx2 = 0, viol_rx2 = 0, viol_sel = 0, viol_idle = 0;
  logic        prev_txwr = 1'b0, prev_tbusy = 1'b0, prev_rxack = 1'b0;

  always @(negedge clk) begin
    if (tx_wr) begin
      tx_log[8'(tx_n)] <= tx_data;
      tx_cyc[8'(tx_n)] <= cyc_n;
      tx_n <= tx_n + 1;
      if (!prev_txwr && prev_tbusy) viol_tx <= viol_tx + 1;
      if (prev_txwr) viol_tx2 <= viol_tx2 + 1;
    end
    if (rx_ack) begin
      rxack_n <= rxack_n + 1;
      last_rxack_cyc <= cyc_n;
      if (prev_rxack) viol_rx2 <= viol_rx2 + 1;
    end
    if (wb_cyc_o && wb_stb_o) begin
      cur_run  <= cur_run + 1;
      last_adr <= wb_adr_o;
      last_dat <= wb_dat_o;
      last_we  <= wb_we_o;
      if (wb_sel_o != 4'hF) viol_sel <= viol_sel + 1;
    end else begin
      if (cur_run != 0) begin
        last_run <= cur_run;
        bus_n    <= bus_n + 1;
        cur_run  <= 0;
      end
      if (wb_cyc_o || wb_stb_o || wb_we_o || wb_sel_o != 4'd0) viol_idle <= viol_idle + 1;
    end
    prev_txwr  <= tx_wr;
    prev_tbusy <= tx_busy;
    prev_rxack <= rx_ack;
  end

  always @(posedge clk) begin
    if (cyc_n > 90000) begin
      $display("FAIL watchdog: cycle %0d reached, limit 90000", cyc_n);
      $fatal(1);
    end
  end

  typedef struct {
    string       name;
    logic [7:0]  op;
    logic [31:0] adr;
    logic [31:0] dat;
    int          ncmd;
    logic        ack_en;
    int          lat;
    logic [31:0] rd;
    int          busy_len;
    logic [39:0] resp;
    int          nresp;
    int          run;
    logic        we;
  } vec_t;

  function automatic vec_t mk(string name, logic [7:0] op, logic [31:0] adr,
                              logic [31:0] dat, int ncmd, logic en, int lat,
                              logic [31:0] rd, int bl, logic [39:0] resp,
                              int nresp, int run, logic we);
    vec_t v;
    v.name = name; v.op = op; v.adr = adr; v.dat = dat; v.ncmd = ncmd;
    v.ack_en = en; v.lat = lat; v.rd = rd; v.busy_len = bl;
    v.resp = resp; v.nresp = nresp; v.run = run; v.we = we;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic push(input logic [7:0] b);
    rx_buf[wr_ptr] = b;
    wr_ptr = wr_ptr + 8'd1;
  endtask

  task automatic push_cmd(input vec_t v);
    push(v.op);
    if (v.ncmd >= 5) for (int i = 0; i < 4; i++) push(v.adr[31-8*i -: 8]);
    if (v.ncmd >= 9) for (int i = 0; i < 4; i++) push(v.dat[31-8*i -: 8]);
  endtask

  // Wait until all bytes are consumed and both DUT and transmitter are idle.
  task automatic wait_done(input string name);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(rd_ptr == wr_ptr && !busy && !tx_busy && !tx_wr) && n < 3000);
    check({name, ".done"}, 32'(n < 3000), 32'd1);
    repeat (3) @(negedge clk);
  endtask

  task automatic run_vec(input vec_t v);
    int t0, r0, b0;
    ack_en = v.ack_en; ack_lat = v.lat; rd_val = v.rd; busy_len = v.busy_len;
    @(negedge clk);
    t0 = tx_n; r0 = rxack_n; b0 = bus_n;
    push_cmd(v);
    wait_done(v.name);
    check({v.name, ".ntx"}, 32'(tx_n - t0), 32'(v.nresp));
    for (int i = 0; i < v.nresp; i++)
      check($sformatf("%s.tx%0d", v.name, i), 32'(tx_log[8'(t0 + i)]), 32'(v.resp[39-8*i -: 8]));
    check({v.name, ".rxack"}, 32'(rxack_n - r0), 32'(v.ncmd));
    check({v.name, ".nbus"}, 32'(bus_n - b0), 32'(v.run > 0 ? 1 : 0));
    if (v.run > 0) begin
      check({v.name, ".run"}, 32'(last_run), 32'(v.run));
      check({v.name, ".adr"}, last_adr, v.adr);
      check({v.name, ".we"}, 32'(last_we), 32'(v.we));
      if (v.we) begin
        check({v.name, ".dat"}, last_dat, v.dat);
        check({v.name, ".dat_hold"}, wb_dat_o, v.dat);
      end
    end
    check({v.name, ".latency"}, 32'(tx_cyc[8'(t0)] - last_rxack_cyc), 32'(v.run + 1));
  endtask

  vec_t vecs [7];
  vec_t v_rd, v_wr;

  initial begin
    vecs[0] = mk("wr",      8'h57, 32'h0000_1004, 32'hDEAD_BEEF, 9, 1'b1, 1, 32'h0,         0, 40'h4B_0000_0000, 1, 2, 1'b1);
    vecs[1] = mk("rd",      8'h52, 32'h0000_0008, 32'h0,         5, 1'b1, 3, 32'h1234_5678, 5, 40'h4B_1234_5678, 5, 4, 1'b0);
    vecs[2] = mk("rd_to",   8'h52, 32'h0000_0020, 32'h0,         5, 1'b0, 0, 32'h0,         2, 40'h45_0000_0000, 1, 8, 1'b0);
    vecs[3] = mk("bad",     8'h41, 32'h0,         32'h0,         1, 1'b1, 0, 32'h0,         0, 40'h3F_0000_0000, 1, 0, 1'b0);
    vecs[4] = mk("rd_edge", 8'h52, 32'h0000_0100, 32'h0,         5, 1'b1, 7, 32'hA5A5_0F0F, 3, 40'h4B_A5A5_0F0F, 5, 8, 1'b0);
    vecs[5] = mk("wr_fast", 8'h57, 32'h8000_0000, 32'h0102_0304, 9, 1'b1, 0, 32'h0,         1, 40'h4B_0000_0000, 1, 1, 1'b1);
    vecs[6] = mk("wr_to",   8'h57, 32'h0000_0040, 32'h55AA_55AA, 9, 1'b0, 0, 32'h0,         0, 40'h45_0000_0000, 1, 8, 1'b1);

    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst.ctl", 32'({rx_ack, tx_wr, wb_cyc_o, wb_stb_o, wb_we_o, busy, wb_sel_o}), 32'd0);
    check("rst.tx_data", 32'(tx_data), 32'd0);
    check("rst.adr", wb_adr_o, 32'd0);
    check("rst.dat", wb_dat_o, 32'd0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 7; i++) run_vec(vecs[i]);

    // Reset while a read sits in BUS: bus drops next edge, no response.
    begin
      int t0, n;
      ack_en = 1'b0; busy_len = 0;
      t0 = tx_n;
      v_rd = mk("rst_rd", 8'h52, 32'h0000_0100, 32'h0, 5, 1'b0, 0, 32'h0, 0, 40'h0, 0, 0, 1'b0);
      push_cmd(v_rd);
      n = 0;
      while (!wb_stb_o && n < 200) begin
        @(negedge clk);
        n++;
      end
      check("rst_mid.bus_started", 32'(n < 200), 32'd1);
      repeat (2) @(negedge clk);
      reset_n = 1'b0;
      @(negedge clk);
      check("rst_mid.cyc_stb", 32'({wb_cyc_o, wb_stb_o}), 32'd0);
      check("rst_mid.busy", 32'(busy), 32'd0);
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      repeat (20) @(negedge clk);
      check("rst_mid.no_tx", 32'(tx_n - t0), 32'd0);
    end
    v_wr = mk("after_rst", 8'h57, 32'h0000_2000, 32'h1357_9BDF, 9, 1'b1, 1, 32'h0, 0, 40'h4B_0000_0000, 1, 2, 1'b1);
    run_vec(v_wr);

    // Back-to-back: read then write queued together, slow transmitter.
    begin
      int t0, r0;
      logic [7:0] exp_b [6];
      exp_b[0] = 8'h4B; exp_b[1] = 8'hCA; exp_b[2] = 8'hFE;
      exp_b[3] = 8'hF0; exp_b[4] = 8'h0D; exp_b[5] = 8'h4B;
      ack_en = 1'b1; ack_lat = 2; rd_val = 32'hCAFE_F00D; busy_len = 5;
      @(negedge clk);
      t0 = tx_n; r0 = rxack_n;
      v_rd = mk("b2b_rd", 8'h52, 32'h0000_0004, 32'h0, 5, 1'b1, 2, 32'h0, 5, 40'h0, 0, 0, 1'b0);
      v_wr = mk("b2b_wr", 8'h57, 32'h0000_3000, 32'h2468_ACE0, 9, 1'b1, 2, 32'h0, 5, 40'h0, 0, 0, 1'b1);
      push_cmd(v_rd);
      push_cmd(v_wr);
      wait_done("b2b");
      check("b2b.ntx", 32'(tx_n - t0), 32'd6);
      for (int i = 0; i < 6; i++)
        check($sformatf("b2b.tx%0d", i), 32'(tx_log[8'(t0 + i)]), 32'(exp_b[i]));
      check("b2b.rxack", 32'(rxack_n - r0), 32'd14);
      check("b2b.adr", last_adr, 32'h0000_3000);
      check("b2b.dat", last_dat, 32'h2468_ACE0);
    end

    repeat (2) @(negedge clk);
    check("viol.tx_while_busy", 32'(viol_tx), 32'd0);
    check("viol.tx_wr_adjacent", 32'(viol_tx2), 32'd0);
    check("viol.rx_ack_adjacent", 32'(viol_rx2), 32'd0);
    check("viol.sel_in_cycle", 32'(viol_sel), 32'd0);
    check("viol.idle_bus", 32'(viol_idle), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
